// File: rtl/dm_lane_ctrl.sv
// Data-memory responder: one load/store at a time against a word RAM, with byte/halfword lanes.
// Optional DM_ALIGN_CHECK_EN: fault when Addr[1:0] does not match the lane named by the code.
//
// state | meaning
// IDLE  | ready for a request; stores commit to RAM at the accept edge
// RD    | RAM read data available; extension applied and registered
// RESP  | RespValid pulse for one cycle
module dm_lane_ctrl #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ReqValid,
  output logic        ReqReady,
  input  logic        ReqWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  WriteMemDataLength,
  input  logic [3:0]  ReadMemExtSignal,
  output logic        RespValid,
  output logic [31:0] ReadData,
  output logic        AccessFault
);

  typedef enum logic [1:0] {IDLE, RD, RESP} state_t;

  localparam int DEPTH = 1 << DEPTH_LOG2;

  state_t                state, state_nxt;
  logic [31:0]           ram [DEPTH];
  logic [31:0]           ram_q;
  logic [3:0]            ext_q;
  logic [31:0]           off;
  logic [DEPTH_LOG2-1:0] idx;
  logic                  in_range, code_ok, align_ok, fault, accept;
  logic                  wr_en, rd_en;
  logic [3:0]            be;
  logic [31:0]           wdata;

  assign off      = Addr - BASE_ADDR;
  assign idx      = off[DEPTH_LOG2+1:2];
  assign in_range = (Addr >= BASE_ADDR) && ((off >> (DEPTH_LOG2 + 2)) == 32'd0);
  assign code_ok  = ReqWrite ? (WriteMemDataLength != 3'd7) : (ReadMemExtSignal <= 4'd12);

`ifdef DM_ALIGN_CHECK_EN
  logic [1:0] need_lo;

  always_comb begin
    need_lo = 2'b00;
    if (ReqWrite) begin
      case (WriteMemDataLength)
        3'd2, 3'd5: need_lo = 2'b10;
        3'd4:       need_lo = 2'b01;
        3'd6:       need_lo = 2'b11;
        default:    need_lo = 2'b00;
      endcase
    end else begin
      case (ReadMemExtSignal)
        4'd2, 4'd4, 4'd7, 4'd11: need_lo = 2'b10;
        4'd6, 4'd10:             need_lo = 2'b01;
        4'd8, 4'd12:             need_lo = 2'b11;
        default:                 need_lo = 2'b00;
      endcase
    end
  end

  assign align_ok = (Addr[1:0] == need_lo);
`else
  assign align_ok = 1'b1;
`endif

  assign fault     = !(in_range && code_ok && align_ok);
  assign ReqReady  = rst_n && (state == IDLE);
  assign accept    = ReqValid && ReqReady;
  assign RespValid = rst_n && (state == RESP);

  // Store data is replicated across lanes so the byte enables alone pick the target bytes.
  always_comb begin
    be    = 4'b0000;
    wdata = {4{WriteData[7:0]}};
    case (WriteMemDataLength)
      3'd0: begin be = 4'b1111; wdata = WriteData; end
      3'd1: begin be = 4'b0011; wdata = {2{WriteData[15:0]}}; end
      3'd2: begin be = 4'b1100; wdata = {2{WriteData[15:0]}}; end
      3'd3: be = 4'b0001;
      3'd4: be = 4'b0010;
      3'd5: be = 4'b0100;
      3'd6: be = 4'b1000;
      default: be = 4'b0000;
    endcase
  end

  always_comb begin
    state_nxt = state;
    wr_en     = 1'b0;
    rd_en     = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (fault) begin
            state_nxt = RESP;
          end else if (ReqWrite) begin
            wr_en     = 1'b1;
            state_nxt = RESP;
          end else begin
            rd_en     = 1'b1;
            state_nxt = RD;
          end
        end
      end
      RD:      state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  function automatic logic [31:0] extend(input logic [31:0] w, input logic [3:0] code);
    logic [31:0] r;
    case (code)
      4'd0:    r = w;
      4'd1:    r = {{16{w[15]}}, w[15:0]};
      4'd2:    r = {{16{w[31]}}, w[31:16]};
      4'd3:    r = {16'h0000, w[15:0]};
      4'd4:    r = {16'h0000, w[31:16]};
      4'd5:    r = {{24{w[7]}},  w[7:0]};
      4'd6:    r = {{24{w[15]}}, w[15:8]};
      4'd7:    r = {{24{w[23]}}, w[23:16]};
      4'd8:    r = {{24{w[31]}}, w[31:24]};
      4'd9:    r = {24'h0, w[7:0]};
      4'd10:   r = {24'h0, w[15:8]};
      4'd11:   r = {24'h0, w[23:16]};
      4'd12:   r = {24'h0, w[31:24]};
      default: r = 32'h0;
    endcase
    return r;
  endfunction

  // RAM array carries no reset so it maps onto a plain synchronous memory.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      if (be[0]) ram[idx][7:0]   <= wdata[7:0];
      if (be[1]) ram[idx][15:8]  <= wdata[15:8];
      if (be[2]) ram[idx][23:16] <= wdata[23:16];
      if (be[3]) ram[idx][31:24] <= wdata[31:24];
    end
    if (rd_en) ram_q <= ram[idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      ext_q       <= 4'd0;
      ReadData    <= 32'h0;
      AccessFault <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && accept) begin
        if (fault || ReqWrite) begin
          ReadData    <= 32'h0;
          AccessFault <= fault;
        end else begin
          ext_q <= ReadMemExtSignal;
        end
      end
      if (state == RD) begin
        ReadData    <= extend(ram_q, ext_q);
        AccessFault <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dm_lane_ctrl.sv
// Randomized self-checking bench for dm_lane_ctrl against a byte-array memory model.
// Honors DM_ALIGN_CHECK_EN so expectations follow the same build option as the RTL.
module tb_dm_lane_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ReqValid;
  logic        ReqReady;
  logic        ReqWrite;
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic [2:0]  WriteMemDataLength;
  logic [3:0]  ReadMemExtSignal;
  logic        RespValid;
  logic [31:0] ReadData;
  logic        AccessFault;

  int n_chk = 0;
  int n_err = 0;

  logic [7:0]  mem [4096];
  logic [31:0] r;
  logic        af;

  always #5 clk = ~clk;

  dm_lane_ctrl dut (
    .clk                (clk),
    .rst_n              (rst_n),
    .ReqValid           (ReqValid),
    .ReqReady           (ReqReady),
    .ReqWrite           (ReqWrite),
    .Addr               (Addr),
    .WriteData          (WriteData),
    .WriteMemDataLength (WriteMemDataLength),
    .ReadMemExtSignal   (ReadMemExtSignal),
    .RespValid          (RespValid),
    .ReadData           (ReadData),
    .AccessFault        (AccessFault)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Byte lane (lo), byte count (n), signedness and legality of a code.
  function automatic void model_lanes(input bit wr, input logic [2:0] wl, input logic [3:0] ex,
                                      output int lo, output int n, output bit sgn, output bit ok);
    lo = 0; n = 4; sgn = 1'b0; ok = 1'b1;
    if (wr) begin
      if (wl == 3'd0) begin
      end else if (wl <= 3'd2) begin
        n = 2; lo = (wl == 3'd2) ? 2 : 0;
      end else if (wl <= 3'd6) begin
        n = 1; lo = int'(wl) - 3;
      end else ok = 1'b0;
    end else begin
      if (ex == 4'd0) begin
      end else if (ex <= 4'd4) begin
        n = 2; lo = (ex == 4'd2 || ex == 4'd4) ? 2 : 0; sgn = (ex <= 4'd2);
      end else if (ex <= 4'd12) begin
        n = 1; sgn = (ex <= 4'd8); lo = (int'(ex) - 5) % 4;
      end else ok = 1'b0;
    end
  endfunction

  task automatic xact(input bit wr, input logic [31:0] a, input logic [31:0] d,
                      input logic [2:0] wl, input logic [3:0] ex,
                      output logic [31:0] rd_o, output logic af_o);
    int lo, n, w, lat, pulses;
    bit sgn, ok, flt;
    longint v;
    logic [31:0] exp_rd;
    model_lanes(wr, wl, ex, lo, n, sgn, ok);
    flt = !ok || (a >= 32'd4096);
`ifdef DM_ALIGN_CHECK_EN
    if (a[1:0] != lo[1:0]) flt = 1'b1;
`endif
    exp_rd = 32'h0;
    if (!flt) begin
      w = int'(a >> 2) * 4 + lo;
      if (wr) begin
        for (int k = 0; k < n; k++) mem[w+k] = d[8*k +: 8];
      end else begin
        v = 0;
        for (int k = 0; k < n; k++) v = v | (longint'(mem[w+k]) << (8*k));
        if (sgn && v[8*n-1]) v = v - (longint'(1) << (8*n));
        exp_rd = v[31:0];
      end
    end

    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = wr; Addr = a; WriteData = d;
    WriteMemDataLength = wl; ReadMemExtSignal = ex;
    w = 0;
    while (!ReqReady && w < 8) begin @(negedge clk); w++; end
    chk("req_ready", 32'(ReqReady), 32'd1);
    @(posedge clk);
    #1;
    ReqValid = 1'b0; ReqWrite = 1'($urandom); Addr = $urandom; WriteData = $urandom;
    WriteMemDataLength = 3'($urandom); ReadMemExtSignal = 4'($urandom);
    lat = 0; pulses = 0; rd_o = 32'h0; af_o = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      if (i == 1) chk("busy_not_ready", 32'(ReqReady), 32'd0);
      if (RespValid) begin
        pulses++;
        if (lat == 0) begin
          lat = i; rd_o = ReadData; af_o = AccessFault;
          chk("fault", 32'(AccessFault), 32'(flt));
          chk("rdata", ReadData, exp_rd);
        end
      end
    end
    chk("resp_pulses", 32'(pulses), 32'd1);
    chk("latency", 32'(lat), (wr || flt) ? 32'd1 : 32'd2);
  endtask

  initial begin
    rst_n = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    WriteMemDataLength = 3'd0; ReadMemExtSignal = 4'd0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(ReqReady), 32'd0);
    chk("rst_respvalid", 32'(RespValid), 32'd0);
    chk("rst_rdata", ReadData, 32'h0);
    chk("rst_fault", 32'(AccessFault), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(ReqReady), 32'd1);

    for (int i = 0; i < 32; i++) xact(1'b1, 32'(i * 4), $urandom, 3'd0, 4'd0, r, af);
    xact(1'b1, 32'hFFC, 32'h1234_5678, 3'd0, 4'd0, r, af);
    xact(1'b0, 32'hFFC, 32'h0, 3'd0, 4'd0, r, af);
    chk("top_word", r, 32'h1234_5678);

    xact(1'b1, 32'h10, 32'h8899_AABB, 3'd0, 4'd0, r, af);
    xact(1'b0, 32'h10, 32'h0, 3'd0, 4'd0, r, af);
    chk("dword_load", r, 32'h8899_AABB);
    xact(1'b1, 32'h12, 32'h0000_00F0, 3'd5, 4'd0, r, af);
    xact(1'b0, 32'h10, 32'h0, 3'd0, 4'd0, r, af);
    chk("byte_high_word", r, 32'h88F0_AABB);
    xact(1'b0, 32'h12, 32'h0, 3'd0, 4'd7, r, af);
    chk("s_byte_high", r, 32'hFFFF_FFF0);
    xact(1'b0, 32'h12, 32'h0, 3'd0, 4'd11, r, af);
    chk("u_byte_high", r, 32'h0000_00F0);

    xact(1'b1, 32'h20, 32'h0, 3'd0, 4'd0, r, af);
    xact(1'b1, 32'h22, 32'h0000_8001, 3'd2, 4'd0, r, af);
    xact(1'b0, 32'h20, 32'h0, 3'd0, 4'd0, r, af);
    chk("word_high_word", r, 32'h8001_0000);
    xact(1'b0, 32'h22, 32'h0, 3'd0, 4'd2, r, af);
    chk("s_word_high", r, 32'hFFFF_8001);
    xact(1'b0, 32'h22, 32'h0, 3'd0, 4'd4, r, af);
    chk("u_word_high", r, 32'h0000_8001);
    xact(1'b0, 32'h20, 32'h0, 3'd0, 4'd1, r, af);
    chk("s_word_low", r, 32'h0000_0000);

    xact(1'b1, 32'h1000, 32'hDEAD_BEEF, 3'd0, 4'd0, r, af);
    chk("oor_store_fault", 32'(af), 32'd1);
    xact(1'b0, 32'h0, 32'h0, 3'd0, 4'd0, r, af);
    chk("oor_no_alias_write", r, {mem[3], mem[2], mem[1], mem[0]});
    xact(1'b0, 32'h10, 32'h0, 3'd0, 4'd14, r, af);
    chk("ext14_fault", 32'(af), 32'd1);
    xact(1'b1, 32'h10, 32'h0, 3'd7, 4'd0, r, af);
    chk("lane7_fault", 32'(af), 32'd1);

    xact(1'b1, 32'h10, 32'h0000_005A, 3'd4, 4'd0, r, af);
    xact(1'b0, 32'h10, 32'h0, 3'd0, 4'd0, r, af);
`ifdef DM_ALIGN_CHECK_EN
    chk("byte_low_misaligned", r, 32'h88F0_AABB);
`else
    chk("byte_low_unchecked", r, 32'h88F0_5ABB);
`endif

    // Reset while the load sits in RD: the response must never appear.
    @(negedge clk);
    ReqValid = 1'b1; ReqWrite = 1'b0; Addr = 32'h20; ReadMemExtSignal = 4'd0;
    @(posedge clk);
    #1 ReqValid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    chk("rst_in_rd_resp", 32'(RespValid), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("rst_in_rd_resp", 32'(RespValid), 32'd0);
      chk("rst_in_rd_ready", 32'(ReqReady), 32'd0);
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_release_ready", 32'(ReqReady), 32'd1);
    chk("rst_release_resp", 32'(RespValid), 32'd0);
    xact(1'b0, 32'h20, 32'h0, 3'd0, 4'd0, r, af);
    chk("load_after_rst", r, 32'h8001_0000);

    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = 32'($urandom_range(0, 127));
      if ($urandom_range(0, 9) == 0) a = 32'h1000 + $urandom_range(0, 32'h0FFF_0000);
      xact(1'($urandom), a, $urandom, 3'($urandom_range(0, 7)), 4'($urandom_range(0, 15)), r, af);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
